// File: rtl/ifetch_pkg.sv
// Shared widths and the instruction-buffer entry type for the fetch block.
package ifetch_pkg;

  localparam int PC_W       = 30;
  localparam int INST_W     = 32;
  localparam int IBUF_DEPTH = 2;
  localparam int CNT_W      = $clog2(IBUF_DEPTH + 1);
  localparam int PTR_W      = $clog2(IBUF_DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ibuf_entry_t;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bus bundle: instruction ROM port, redirect request and decode-side stream.
interface inst_fetch_if;
  import ifetch_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              redirect;
  logic [PC_W-1:0]   redirect_target;
  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;

  modport master (
    output imem_addr, if_valid, if_inst, if_pc,
    input  imem_inst, redirect, redirect_target, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_inst, if_pc,
    output imem_inst, redirect, redirect_target, if_ready
  );

endinterface

// File: rtl/ifetch_buf.sv
// Small {inst,pc} FIFO between the ROM response and decode; flush empties it in one cycle.
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  ibuf_entry_t      wr_data,
  output ibuf_entry_t      head,
  output logic [CNT_W-1:0] count
);

  ibuf_entry_t      mem [IBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: one ROM request in flight, 2-entry buffer, redirect flush.
// Optional IF_BYPASS_EN forwards the ROM response straight to decode when the buffer is empty.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 30'h0
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  fetch_addr;
  logic             inflight;
  logic [PC_W-1:0]  inflight_pc;
  logic [CNT_W-1:0] buf_count;
  ibuf_entry_t      buf_head;
  ibuf_entry_t      wr_entry;
  logic             bypass;
  logic             valid;
  logic             pop;
  logic             push;
  logic             buf_pop;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  always_comb begin
    fetch_addr = bus.redirect ? bus.redirect_target : fetch_pc;
    bus.imem_addr = fetch_addr;

`ifdef IF_BYPASS_EN
    bypass = (buf_count == '0) & inflight & ~bus.redirect;
`else
    bypass = 1'b0;
`endif

    valid        = (buf_count != '0) | bypass;
    bus.if_valid = valid;
    bus.if_inst  = bypass ? bus.imem_inst : buf_head.inst;
    bus.if_pc    = bypass ? inflight_pc   : buf_head.pc;

    pop     = valid & bus.if_ready & ~bus.redirect;
    // a bypassed response that decode takes this cycle never enters the buffer
    push    = inflight & ~bus.redirect & ~(bypass & pop);
    buf_pop = pop & ~bypass;

    wr_entry.inst = bus.imem_inst;
    wr_entry.pc   = inflight_pc;

    occupancy = {1'b0, buf_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    issue     = bus.redirect | (occupancy < (CNT_W+1)'(IBUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_addr;
        fetch_pc    <= pc_next(fetch_addr);
      end
    end
  end

  ifetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (buf_pop),
    .flush   (bus.redirect),
    .wr_data (wr_entry),
    .head    (buf_head),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: accepted stream checked against an ideal in-order pc/ROM model.
module tb_inst_fetch;

`ifdef IF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus ();
  inst_fetch_if bus2 ();

  inst_fetch #(.RESET_PC(30'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  inst_fetch #(.RESET_PC(30'h3FFFFFFE)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a)
      30'h0:   rom = 32'h3c081000;
      30'h1:   rom = 32'h350800b0;
      30'h2:   rom = 32'h3c091000;
      30'h1A:  rom = 32'h15100003;
      default: rom = {a, 2'b11} ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // registered ROM: data for the address seen at this edge appears after it
  always @(posedge clk) begin
    bus.imem_inst  <= rom(bus.imem_addr);
    bus2.imem_inst <= rom(bus2.imem_addr);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [29:0] exp_pc;
  logic [29:0] exp_pc2;
  logic        saw_valid;
  logic [29:0] last_pc;
  logic [31:0] last_inst;
  logic [29:0] hold_addr;
  logic [29:0] wrap_log[$];
  logic [29:0] wrap_exp[4];
  int          waited;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one cycle: drive at negedge, sample just after, score accepted instructions
  task automatic tick(input logic rdy, input logic rd, input logic [29:0] tgt);
    @(negedge clk);
    bus.if_ready        = rdy;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    #2;
    saw_valid = bus.if_valid;
    last_pc   = bus.if_pc;
    last_inst = bus.if_inst;
    if (bus.if_valid && rdy && !rd) begin
      check("acc_pc", 32'(bus.if_pc), 32'(exp_pc));
      check("acc_inst", bus.if_inst, rom(exp_pc));
      exp_pc = exp_pc + 30'd1;
    end
    if (rd) exp_pc = tgt;
    if (bus2.if_valid) begin
      check("wrap_pc", 32'(bus2.if_pc), 32'(exp_pc2));
      check("wrap_inst", bus2.if_inst, rom(exp_pc2));
      if (wrap_log.size() < 4) wrap_log.push_back(bus2.if_pc);
      exp_pc2 = exp_pc2 + 30'd1;
    end
  endtask

  initial begin
    bus.if_ready = 1'b0;  bus.redirect = 1'b0;  bus.redirect_target = '0;
    bus2.if_ready = 1'b1; bus2.redirect = 1'b0; bus2.redirect_target = '0;
    exp_pc  = 30'h0;
    exp_pc2 = 30'h3FFFFFFE;
    wrap_exp[0] = 30'h3FFFFFFE; wrap_exp[1] = 30'h3FFFFFFF;
    wrap_exp[2] = 30'h0;        wrap_exp[3] = 30'h1;

    repeat (3) @(negedge clk);
    #2;
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_inst", bus.if_inst, 32'd0);
    check("rst_pc", 32'(bus.if_pc), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_addr_wrap", 32'(bus2.imem_addr), 32'h3FFFFFFE);

    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 1'b0, '0);
    check("first_lat_a", 32'(saw_valid), (LAT == 1) ? 32'd1 : 32'd0);
    tick(1'b1, 1'b0, '0);
    check("first_lat_b", 32'(saw_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, '0);
      check("throughput", 32'(saw_valid), 32'd1);
    end

    // stall: buffer fills, fetch stops two ahead of the head
    repeat (5) tick(1'b0, 1'b0, '0);
    check("stall_valid", 32'(bus.if_valid), 32'd1);
    check("stall_addr", 32'(bus.imem_addr), 32'(bus.if_pc + 30'd2));
    hold_addr = bus.imem_addr;
    tick(1'b0, 1'b0, '0);
    check("stall_hold", 32'(bus.imem_addr), 32'(hold_addr));
    repeat (8) tick(1'b1, 1'b0, '0);

    // redirect with the buffer full
    repeat (4) tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 30'h1A);
    waited = 0;
    saw_valid = 1'b0;
    while (!saw_valid && waited < 6) begin
      tick(1'b1, 1'b0, '0);
      waited++;
    end
    check("redir_lat", 32'(waited), 32'(LAT));
    check("redir_pc", 32'(last_pc), 32'h1A);
    check("redir_inst", last_inst, 32'h15100003);
    repeat (4) tick(1'b1, 1'b0, '0);

    // redirect in the same cycle decode would have taken the head
    tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 30'h100);
    check("redir_pop_valid", 32'(saw_valid), 32'd1);
    waited = 0;
    saw_valid = 1'b0;
    while (!saw_valid && waited < 6) begin
      tick(1'b1, 1'b0, '0);
      waited++;
    end
    check("redir_pop_pc", 32'(last_pc), 32'h100);
    repeat (3) tick(1'b1, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0,
           $urandom_range(0, 11) == 0,
           ($urandom_range(0, 3) == 0) ? 30'($urandom) : 30'($urandom_range(0, 40)));
    end
    repeat (4) tick(1'b1, 1'b0, '0);

    // reset mid-stream with buffered and in-flight instructions
    tick(1'b0, 1'b0, '0);
    #1;
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.if_valid), 32'd0);
    check("mrst_pc", 32'(bus.if_pc), 32'd0);
    check("mrst_inst", bus.if_inst, 32'd0);
    check("mrst_addr", 32'(bus.imem_addr), 32'd0);
    exp_pc  = 30'h0;
    exp_pc2 = 30'h3FFFFFFE;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 1'b0, '0);
    check("mrst_lat_a", 32'(saw_valid), (LAT == 1) ? 32'd1 : 32'd0);
    tick(1'b1, 1'b0, '0);
    check("mrst_lat_b", 32'(saw_valid), 32'd1);
    check("mrst_first_pc", 32'(last_pc), (LAT == 1) ? 32'd1 : 32'd0);
    repeat (10) tick(1'b1, 1'b0, '0);

    check("wrap_count", 32'(wrap_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wrap_log.size(); i++)
      check("wrap_seq", 32'(wrap_log[i]), 32'(wrap_exp[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
